// File: rtl/cv32e40p_clock_gate_ctrl.sv
// ----------------------------------------------------------------------------
// cv32e40p_clock_gate_ctrl
//
// Sleep/wake sequencer for the core-level latch-based clock gate. It runs on
// the free-running (ungated) clock. After a WFI-style sleep request it waits
// until the pipeline has been idle for IDLE_HOLD consecutive cycles and then
// drops the gate enable. Any wake event re-enables the clock. The block also
// keeps a saturating count of the cycles spent gated, for power profiling.
//
// Ports:
//   clk_i          free-running ungated clock
//   rst_ni         asynchronous active-low reset
//   fetch_enable_i core start permission, only looked at while waiting after reset
//   sleep_req_i    level, core has executed WFI and requests sleep
//   core_busy_i    level, pipeline or LSU still has outstanding work
//   wake_i         level, pending enabled IRQ or debug request
//   clock_en_o     registered enable for the clock gate en_i
//   core_sleep_o   registered, high while the core clock is gated
//   wake_pulse_o   registered single-cycle pulse on the way out of sleep
//   sleep_cycles_o saturating count of cycles spent asleep
// ----------------------------------------------------------------------------
module cv32e40p_clock_gate_ctrl #(
    parameter int IDLE_HOLD = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fetch_enable_i,
    input  logic             sleep_req_i,
    input  logic             core_busy_i,
    input  logic             wake_i,
    output logic             clock_en_o,
    output logic             core_sleep_o,
    output logic             wake_pulse_o,
    output logic [CNT_W-1:0] sleep_cycles_o
);

    // The idle counter is 8 bits wide, so the hold time must fit in it.
    generate
        if (IDLE_HOLD < 1 || IDLE_HOLD > 255) begin : g_bad_idle_hold
            $error("IDLE_HOLD must be in the range 1..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_LAST = 8'(IDLE_HOLD - 1);

    typedef enum logic [2:0] {
        S_RESET_WAIT,
        S_RUN,
        S_DRAIN,
        S_SLEEP,
        S_WAKE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
    logic             clock_en_q, clock_en_d;
    logic             core_sleep_q, core_sleep_d;
    logic             wake_pulse_q, wake_pulse_d;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_RESET_WAIT;
            idle_cnt_q   <= '0;
            sleep_cnt_q  <= '0;
            clock_en_q   <= 1'b0;
            core_sleep_q <= 1'b0;
            wake_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            sleep_cnt_q  <= sleep_cnt_d;
            clock_en_q   <= clock_en_d;
            core_sleep_q <= core_sleep_d;
            wake_pulse_q <= wake_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            S_RESET_WAIT: begin
                if (fetch_enable_i) state_d = S_RUN;
            end
            S_RUN: begin
                // A wake arriving together with the request keeps us running.
                if (sleep_req_i && !wake_i) begin
                    state_d    = S_DRAIN;
                    idle_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (wake_i || !sleep_req_i) begin
                    state_d = S_RUN;
                end else if (core_busy_i) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == HOLD_LAST) begin
                    state_d = S_SLEEP;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            S_SLEEP: begin
                if (wake_i) state_d = S_WAKE;
            end
            S_WAKE: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RESET_WAIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic, decoded from the next state so the outputs change on
    // the same rising edge as the state (the gate latches en_i while the
    // clock is low, so rising-edge-only changes keep the gated clock clean).
    // ------------------------------------------------------------------
    always_comb begin
        clock_en_d   = (state_d != S_RESET_WAIT) && (state_d != S_SLEEP);
        core_sleep_d = (state_d == S_SLEEP);
        wake_pulse_d = (state_d == S_WAKE);
        sleep_cnt_d  = sleep_cnt_q;
        if (state_q == S_SLEEP && sleep_cnt_q != '1) begin
            sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
        end
    end

    assign clock_en_o     = clock_en_q;
    assign core_sleep_o   = core_sleep_q;
    assign wake_pulse_o   = wake_pulse_q;
    assign sleep_cycles_o = sleep_cnt_q;

endmodule
